// File: rtl/md_if.sv
// Issue/result bundle between the control path and the multiply/divide unit.
// The control path drives the request; the unit returns status and HI/LO.
interface md_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, in1, in2, input busy, done, hi, lo);
  modport slave  (input start, op, in1, in2, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers: 32-step shift-add multiply,
// 32-step restoring divide, then one FIX cycle that applies signs and writes HI/LO.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo complete here in one cycle
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign correction, HI/LO write, done pulse
module md_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sgn_op;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       sum, shifted, diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo, rem;

  // Magnitude of 0x80000000 is itself when read as unsigned, so WIDTH bits suffice.
  always_comb begin
    sgn_op = bus.op[0];
    mag1   = (sgn_op && bus.in1[WIDTH-1]) ? (~bus.in1 + 1'b1) : bus.in1;
    mag2   = (sgn_op && bus.in2[WIDTH-1]) ? (~bus.in2 + 1'b1) : bus.in2;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    prod_fix  = '0;
    quo       = '0;
    rem       = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000, 3'b001: begin
              state_d   = MUL;
              is_div_d  = 1'b0;
              cnt_d     = 5'd31;
              prod_d    = {{WIDTH{1'b0}}, mag2};
              opnd_d    = mag1;
              neg_d     = sgn_op & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
            end
            3'b010, 3'b011: begin
              state_d   = DIV;
              is_div_d  = 1'b1;
              cnt_d     = 5'd31;
              prod_d    = {{WIDTH{1'b0}}, mag1};
              opnd_d    = mag2;
              neg_d     = sgn_op & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
              neg_rem_d = sgn_op & bus.in1[WIDTH-1];
              dz_d      = (bus.in2 == '0);
            end
            3'b100: begin
              hi_d   = bus.in1;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = bus.in1;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        prod_d = {sum, prod_q[WIDTH-1:1]};
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      DIV: begin
        // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
        shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (!diff[WIDTH]) prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else              prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          quo  = neg_q ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
          rem  = neg_rem_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
          lo_d = dz_q ? '1 : quo;
          hi_d = rem;
        end else begin
          prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed test of md_unit: multiply/divide results, latency, HI/LO moves,
// ignored and back-to-back requests, and reset mid-operation.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad = 0;
  int   lat, bcnt, dcnt;

  md_if #(.WIDTH(32)) bus();

  md_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble inputs to prove they were captured.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!bus.done && l < 60) begin
      if (bus.busy) b++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int l, bc;
    issue(op, a, b);
    wait_done(l, bc);
    check_val({tag, "_lat"}, 64'(l), 64'd33);
    check_val({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check_val({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.in1   = '0;
    bus.in2   = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    run_op("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'b001, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'b010, 32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big",  3'b010, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);
    run_op("mult_both_neg", 3'b001, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000);

    // mthi then mtlo: single-cycle, busy never rises, other register untouched
    issue(3'b100, 32'h1234_5678, 32'd0);
    check_val("mthi_done", 64'(bus.done), 64'd1);
    check_val("mthi_busy", 64'(bus.busy), 64'd0);
    check_val("mthi_hilo", {bus.hi, bus.lo}, {32'h1234_5678, 32'h0000_0000});
    issue(3'b101, 32'hCAFE_BABE, 32'd0);
    check_val("mtlo_done", 64'(bus.done), 64'd1);
    check_val("mtlo_hilo", {bus.hi, bus.lo}, {32'h1234_5678, 32'hCAFE_BABE});

    // reserved op codes do nothing
    issue(3'b110, 32'h5555_5555, 32'd1);
    check_val("noop_done", 64'(bus.done), 64'd0);
    check_val("noop_busy", 64'(bus.busy), 64'd0);
    check_val("noop_hilo", {bus.hi, bus.lo}, {32'h1234_5678, 32'hCAFE_BABE});

    // start while busy is ignored
    issue(3'b000, 32'd3, 32'd5);
    lat = 0;
    while (!bus.done && lat < 60) begin
      if (lat == 4) begin
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.in1   = 32'd100;
        bus.in2   = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("ign_lat", 64'(lat), 64'd33);
    check_val("ign_hilo", {bus.hi, bus.lo}, {32'd0, 32'd15});

    // issue on the done cycle is accepted
    issue(3'b010, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    check_val("b2b_lat", 64'(lat), 64'd33);
    check_val("b2b_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

    // reset mid-operation aborts with no done pulse
    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (bus.done) dcnt++;
      @(posedge clk);
      #1;
    end
    check_val("abort_no_done", 64'(dcnt), 64'd0);

    run_op("multu_after_rst", 3'b000, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
